sbox_column_sequencer: RTL and testbench

Multi-cycle substitution-layer controller for the ASCON permutation. It applies the 5-bit S-box to all 64 columns of the 320-bit state using G_NUM_SBOX shared S-box instances, processing G_NUM_SBOX columns per cycle. Each instance uses the package lookup table C_LUT_SBOX. The block sits between the constant-addition and linear-diffusion stages, and trades area for latency with valid/ready handshakes on both sides.

---
 rtl/sbox_column_sequencer.sv | 82 ++++++++
 tb/tb_sbox_column_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sbox_column_sequencer.sv
// sbox_column_sequencer: column-serial ASCON substitution layer, G_NUM_SBOX columns per cycle
package sbox_column_sequencer_pkg;
  localparam logic [0:31][4:0] C_LUT_SBOX = {
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
endpackage

module sbox_column_sequencer
  import sbox_column_sequencer_pkg::*;
#(
  parameter int G_NUM_SBOX = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [319:0] i_state,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [319:0] o_state,
  output logic         o_busy
);
  localparam int N = 64 / G_NUM_SBOX;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  if (G_NUM_SBOX < 1 || G_NUM_SBOX > 64 || (G_NUM_SBOX & (G_NUM_SBOX - 1)) != 0) begin : g_bad
    $error("G_NUM_SBOX must be one of 1, 2, 4, 8, 16, 32, 64");
  end
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [4:0][63:0] w, nxt;
  logic [5:0] base;
  logic [5:0] col [G_NUM_SBOX];
  logic [4:0] sout [G_NUM_SBOX];
  logic last;
  assign base = 6'(int'(cnt) * G_NUM_SBOX);
  // w[4] is x0, so each column reads MSB-first as {x0,x1,x2,x3,x4}
  for (genvar k = 0; k < G_NUM_SBOX; k++) begin : g_sbox
    assign col[k] = base + 6'(k);
    assign sout[k] = C_LUT_SBOX[{w[4][col[k]], w[3][col[k]], w[2][col[k]], w[1][col[k]], w[0][col[k]]}];
  end
  always_comb begin
    nxt = w;
    for (int k = 0; k < G_NUM_SBOX; k++)
      for (int r = 0; r < 5; r++)
        nxt[r][col[k]] = sout[k][r];
  end
  assign last = cnt == CW'(N - 1);
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= S_IDLE;
      cnt <= '0;
      w <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (i_valid) begin
            w <= i_state;
            cnt <= '0;
            state <= S_RUN;
          end
        S_RUN: begin
          w <= nxt;
          cnt <= last ? '0 : cnt + 1'b1;
          state <= last ? S_DONE : S_RUN;
        end
        S_DONE:
          if (i_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  assign o_ready = state == S_IDLE;
  assign o_valid = state == S_DONE;
  assign o_busy = state == S_RUN || state == S_DONE;
  assign o_state = w;
endmodule

// File: tb/tb_sbox_column_sequencer.sv
// tb_sbox_column_sequencer: random and directed checks of three sequencer widths against a bitsliced ASCON model
module tb_sbox_column_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, iv, ir;
  logic [319:0] din;
  logic rdy [3];
  logic vld [3];
  logic bsy [3];
  logic [319:0] ost [3];
  int n_chk = 0;
  int n_fail = 0;
  localparam int LAT [3] = '{9, 65, 2};
  localparam logic [63:0] ONES = {64{1'b1}};

  sbox_column_sequencer #(.G_NUM_SBOX(8)) u_d8 (
    .i_clock(clk), .i_reset(rst), .i_valid(iv), .o_ready(rdy[0]), .i_state(din),
    .o_valid(vld[0]), .i_ready(ir), .o_state(ost[0]), .o_busy(bsy[0]));
  sbox_column_sequencer #(.G_NUM_SBOX(1)) u_d1 (
    .i_clock(clk), .i_reset(rst), .i_valid(iv), .o_ready(rdy[1]), .i_state(din),
    .o_valid(vld[1]), .i_ready(ir), .o_state(ost[1]), .o_busy(bsy[1]));
  sbox_column_sequencer #(.G_NUM_SBOX(64)) u_d64 (
    .i_clock(clk), .i_reset(rst), .i_valid(iv), .o_ready(rdy[2]), .i_state(din),
    .o_valid(vld[2]), .i_ready(ir), .o_state(ost[2]), .o_busy(bsy[2]));

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [319:0] model(input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] r = '0;
    for (int i = 0; i < 10; i++) r = {r[287:0], 32'($urandom)};
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; iv = 1'b0; ir = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_ready_d%0d", tag, d), 320'(rdy[d]), 320'(1));
      check($sformatf("%s_valid_d%0d", tag, d), 320'(vld[d]), 320'(0));
      check($sformatf("%s_busy_d%0d", tag, d), 320'(bsy[d]), 320'(0));
      check($sformatf("%s_state_d%0d", tag, d), ost[d], 320'(0));
    end
  endtask

  // one transaction through all three widths with i_ready held high
  task automatic run(input logic [319:0] s, input logic [319:0] exp, input string tag);
    logic [319:0] res [3];
    int lat [3];
    lat = '{0, 0, 0};
    @(negedge clk);
    din = s; iv = 1'b1; ir = 1'b1;
    @(negedge clk);
    iv = 1'b0; din = rnd320();
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        if (vld[d] && lat[d] == 0) begin
          lat[d] = c + 1;
          res[d] = ost[d];
        end
      if (c == 1) begin
        check({tag, "_ready_in_run"}, 320'(rdy[0]), 320'(0));
        check({tag, "_busy_in_run"}, 320'(bsy[0]), 320'(1));
      end
      if (c == 9) begin
        check({tag, "_valid_after_handoff"}, 320'(vld[0]), 320'(0));
        check({tag, "_ready_after_handoff"}, 320'(rdy[0]), 320'(1));
      end
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_latency_d%0d", tag, d), 320'(lat[d]), 320'(LAT[d]));
      check($sformatf("%s_state_d%0d", tag, d), res[d], exp);
    end
  endtask

  initial begin
    logic [319:0] s;
    rst = 1'b1; iv = 1'b0; ir = 1'b0; din = '0;
    do_reset();
    chk_reset("reset");
    run('0, {64'h0, 64'h0, ONES, 64'h0, 64'h0}, "zero");
    run({320{1'b1}}, {ONES, 64'h0, ONES, ONES, ONES}, "ones");
    run({256'h0, 64'h1}, {64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h1}, "x4one");
    s = rnd320();
    @(negedge clk);
    din = s; iv = 1'b1; ir = 1'b0;
    @(negedge clk);
    iv = 1'b0;
    repeat (8) @(negedge clk);
    check("bp_valid", 320'(vld[0]), 320'(1));
    check("bp_state", ost[0], model(s));
    for (int i = 0; i < 5; i++) begin
      iv = 1'b1; din = rnd320();
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), 320'(vld[0]), 320'(1));
      check($sformatf("bp_hold_state%0d", i), ost[0], model(s));
      check($sformatf("bp_hold_ready%0d", i), 320'(rdy[0]), 320'(0));
    end
    iv = 1'b0; ir = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 320'(rdy[0]), 320'(1));
    check("bp_release_valid", 320'(vld[0]), 320'(0));
    do_reset();
    @(negedge clk);
    din = rnd320(); iv = 1'b1; ir = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("midrun");
    run('0, {64'h0, 64'h0, ONES, 64'h0, 64'h0}, "after_reset");
    for (int i = 0; i < 6; i++) begin
      s = rnd320();
      run(s, model(s), $sformatf("rnd%0d", i));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
